// File: rtl/user_logic_regbank_irq.sv
// Register bank slave with byte-enable writes, configurable read wait states
// and an optional edge-triggered interrupt block.
// Optional feature: define USER_LOGIC_IRQ_EN to turn the top two registers
// into IRQ_STATUS (rising-edge set, write-1-to-clear) and IRQ_ENABLE.
module user_logic_regbank_irq #(
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_NUM_REG    = 16,
  parameter int unsigned C_SLV_AWIDTH = 6,
  parameter int unsigned C_RD_WAIT    = 1
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic [C_SLV_AWIDTH-1:0]   Bus2IP_Addr,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic                      Bus2IP_WrCE,
  input  logic                      Bus2IP_RdCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_Ack,
  output logic                      IP2Bus_Error,
  input  logic [C_SLV_DWIDTH-1:0]   Evt_In,
  output logic                      Irq
);

  localparam int unsigned IdxW  = C_SLV_AWIDTH - 2;
  localparam int unsigned RegW  = $clog2(C_NUM_REG);
  localparam int unsigned NumBe = C_SLV_DWIDTH / 8;
  localparam logic [IdxW:0] NumRegIdx = (IdxW + 1)'(C_NUM_REG);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [RegW-1:0]         idx_q, idx_d;
  logic                    rd_q, rd_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic [C_SLV_DWIDTH-1:0] data_q, data_d;
  logic [C_SLV_DWIDTH-1:0] be_mask;
  logic [C_SLV_DWIDTH-1:0] regs_q [C_NUM_REG];
  logic [C_SLV_DWIDTH-1:0] regs_d [C_NUM_REG];
  logic [IdxW-1:0]         addr_idx;
  logic                    addr_oob;
  logic                    unused_addr;

  assign addr_idx    = Bus2IP_Addr[C_SLV_AWIDTH-1:2];
  assign addr_oob    = {1'b0, addr_idx} >= NumRegIdx;
  assign unused_addr = ^Bus2IP_Addr[1:0];

  // Expand byte enables into a bit mask for the write merge.
  always_comb begin
    be_mask = '0;
    for (int unsigned b = 0; b < NumBe; b++) begin
      be_mask[8*b +: 8] = {8{Bus2IP_BE[b]}};
    end
  end

  // Transfer FSM: accept in IDLE, optional read wait, single ACK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Bus2IP_WrCE || Bus2IP_RdCE) begin
          idx_d = addr_idx[RegW-1:0];
          rd_d  = Bus2IP_RdCE && !Bus2IP_WrCE;
          err_d = (Bus2IP_WrCE && Bus2IP_RdCE) || addr_oob;
          wr_en = Bus2IP_WrCE && !Bus2IP_RdCE && !addr_oob;
          if (rd_d && (C_RD_WAIT > 0)) begin
            state_d = StWait;
            cnt_d   = 3'(C_RD_WAIT - 1);
          end else begin
            state_d = StAck;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StAck;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data is captured on the edge entering ACK and is zero otherwise.
  always_comb begin
    data_d = '0;
    if ((state_d == StAck) && (state_q != StAck) && rd_d && !err_d) begin
      data_d = regs_q[idx_d];
    end
  end

`ifdef USER_LOGIC_IRQ_EN
  localparam int unsigned StatIdx = C_NUM_REG - 2;
  localparam int unsigned EnIdx   = C_NUM_REG - 1;

  logic [C_SLV_DWIDTH-1:0] evt_q;
  logic [C_SLV_DWIDTH-1:0] evt_rise;
  logic [C_SLV_DWIDTH-1:0] stat_clr;
  logic                    irq_q;

  assign evt_rise = Evt_In & ~evt_q;
  assign stat_clr = (wr_en && (idx_d == RegW'(StatIdx))) ? (Bus2IP_Data & be_mask) : '0;
  assign Irq      = irq_q;

  // Edge-detect history and registered interrupt level.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= Evt_In;
      irq_q <= |(regs_q[StatIdx] & regs_q[EnIdx]);
    end
  end
`else
  logic unused_evt;
  assign unused_evt = ^Evt_In;
  assign Irq        = 1'b0;
`endif

  // Register next state: byte-merged writes, plus status set/clear when enabled.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 0; r < C_NUM_REG; r++) begin
      if (wr_en && (idx_d == RegW'(r))) begin
        regs_d[r] = (regs_q[r] & ~be_mask) | (Bus2IP_Data & be_mask);
      end
    end
`ifdef USER_LOGIC_IRQ_EN
    // A new event wins over a simultaneous write-1-to-clear.
    regs_d[StatIdx] = (regs_q[StatIdx] & ~stat_clr) | evt_rise;
`endif
  end

  // Register bank storage.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      for (int unsigned r = 0; r < C_NUM_REG; r++) regs_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < C_NUM_REG; r++) regs_q[r] <= regs_d[r];
    end
  end

  // FSM and transfer bookkeeping state.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign IP2Bus_Data  = data_q;
  assign IP2Bus_Ack   = (state_q == StAck);
  assign IP2Bus_Error = (state_q == StAck) && err_q;

endmodule

// File: tb/tb_user_logic_regbank_irq.sv
// Self-checking bench for user_logic_regbank_irq: directed scenarios plus a
// randomized transaction run checked against a behavioural register model.
module tb_user_logic_regbank_irq;

  localparam int NREG = 16;
  localparam int RDW  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        wr_ce = 1'b0;
  logic        rd_ce = 1'b0;
  logic [31:0] evt = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [NREG];

  user_logic_regbank_irq #(
    .C_SLV_DWIDTH (32),
    .C_NUM_REG    (NREG),
    .C_SLV_AWIDTH (7),
    .C_RD_WAIT    (RDW)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .Bus2IP_Addr   (addr),
    .Bus2IP_Data   (wdata),
    .Bus2IP_BE     (be),
    .Bus2IP_WrCE   (wr_ce),
    .Bus2IP_RdCE   (rd_ce),
    .IP2Bus_Data   (rdata),
    .IP2Bus_Ack    (ack),
    .IP2Bus_Error  (err),
    .Evt_In        (evt),
    .Irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic exp_irq();
`ifdef USER_LOGIC_IRQ_EN
    return |(model[NREG-2] & model[NREG-1]);
`else
    return 1'b0;
`endif
  endfunction

  // Model of a successful write as seen by the register file.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] m;
    m = bmask(b);
`ifdef USER_LOGIC_IRQ_EN
    if (idx == NREG - 2) begin
      model[idx] = model[idx] & ~(d & m);
      return;
    end
`endif
    model[idx] = (model[idx] & ~m) | (d & m);
  endtask

  // One bus transfer; caller is positioned just after a rising edge.
  task automatic xfer(input bit w, input bit r, input int idx, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] e,
                      output logic [31:0] rd, output logic er, output int lat);
    addr  = 7'(idx * 4);
    wdata = d;
    be    = b;
    wr_ce = w;
    rd_ce = r;
    evt   = e;
    lat   = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 20);
    rd = rdata;
    er = err;
    @(posedge clk); #1;
    wr_ce = 1'b0;
    rd_ce = 1'b0;
    check("ack_single_cycle", {63'd0, ack}, 64'd0);
    check("data_zero_after_ack", {32'd0, rdata}, 64'd0);
  endtask

  logic [31:0] rd_v;
  logic        er_v;
  int          lat_v;
  int          idx;
  bit          is_wr;
  logic [31:0] d;
  logic [3:0]  b;
  int          saw_ack;

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Asynchronous reset with no clock edge yet.
    #3 rst_n = 1'b0;
    #1;
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_data", {32'd0, rdata}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Byte-enable merge on reg1.
    xfer(1, 0, 1, 32'hA5A5A5A5, 4'hF, '0, rd_v, er_v, lat_v);
    check("wr1_lat", 64'(lat_v), 64'd1);
    check("wr1_err", {63'd0, er_v}, 64'd0);
    model_write(1, 32'hA5A5A5A5, 4'hF);
    xfer(1, 0, 1, 32'h000000FF, 4'h1, '0, rd_v, er_v, lat_v);
    check("wr2_lat", 64'(lat_v), 64'd1);
    model_write(1, 32'h000000FF, 4'h1);
    xfer(0, 1, 1, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("rd1_lat", 64'(lat_v), 64'(RDW + 1));
    check("rd1_data", {32'd0, rd_v}, {32'd0, 32'hA5A5A5FF});
    check("rd1_err", {63'd0, er_v}, 64'd0);

    // Randomized transactions, including out-of-range indices.
    for (int t = 0; t < 60; t++) begin
      idx   = $urandom_range(0, 19);
      is_wr = 1'($urandom_range(0, 1));
      d     = $urandom;
      b     = 4'($urandom_range(0, 15));
`ifdef USER_LOGIC_IRQ_EN
      evt = '0;
`else
      evt = $urandom;
`endif
      if (is_wr) begin
        xfer(1, 0, idx, d, b, evt, rd_v, er_v, lat_v);
        check("rnd_wr_lat", 64'(lat_v), 64'd1);
        check("rnd_wr_err", {63'd0, er_v}, {63'd0, idx >= NREG});
        if (idx < NREG) model_write(idx, d, b);
      end else begin
        xfer(0, 1, idx, '0, 4'h0, evt, rd_v, er_v, lat_v);
        check("rnd_rd_lat", 64'(lat_v), 64'(RDW + 1));
        check("rnd_rd_err", {63'd0, er_v}, {63'd0, idx >= NREG});
        check("rnd_rd_data", {32'd0, rd_v}, {32'd0, (idx < NREG) ? model[idx] : 32'd0});
      end
      check("rnd_irq", {63'd0, irq}, {63'd0, exp_irq()});
    end
    evt = '0;

    // Out-of-range index 16 (address 0x40).
    xfer(1, 0, 16, 32'hDEADBEEF, 4'hF, '0, rd_v, er_v, lat_v);
    check("oob_wr_err", {63'd0, er_v}, 64'd1);
    xfer(0, 1, 16, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("oob_rd_err", {63'd0, er_v}, 64'd1);
    check("oob_rd_data", {32'd0, rd_v}, 64'd0);
    for (int i = 0; i < NREG; i++) begin
      xfer(0, 1, i, '0, 4'h0, '0, rd_v, er_v, lat_v);
      check("oob_no_change", {32'd0, rd_v}, {32'd0, model[i]});
    end

    // Both strobes together.
    xfer(1, 1, 3, 32'h12345678, 4'hF, '0, rd_v, er_v, lat_v);
    check("both_err", {63'd0, er_v}, 64'd1);
    check("both_data", {32'd0, rd_v}, 64'd0);
    xfer(0, 1, 3, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("both_no_write", {32'd0, rd_v}, {32'd0, model[3]});

`ifdef USER_LOGIC_IRQ_EN
    // Interrupt status and enable behaviour.
    xfer(1, 0, NREG - 1, 32'h4, 4'hF, '0, rd_v, er_v, lat_v);
    model_write(NREG - 1, 32'h4, 4'hF);
    evt = 32'h4;
    @(posedge clk); #1;
    evt = '0;
    check("irq_lag", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_set", {63'd0, irq}, 64'd1);
    xfer(0, 1, NREG - 2, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("stat_set", {32'd0, rd_v}, 64'h4);
    xfer(1, 0, NREG - 2, 32'h4, 4'hF, '0, rd_v, er_v, lat_v);
    check("irq_clr", {63'd0, irq}, 64'd0);
    xfer(1, 0, NREG - 2, 32'h4, 4'hF, 32'h4, rd_v, er_v, lat_v);
    xfer(0, 1, NREG - 2, '0, 4'h0, 32'h4, rd_v, er_v, lat_v);
    check("set_beats_clr", {32'd0, rd_v}, 64'h4);
    check("irq_after_race", {63'd0, irq}, 64'd1);
    evt = '0;
`else
    // Top registers are plain storage and events are ignored.
    xfer(1, 0, NREG - 2, 32'h0, 4'hF, '0, rd_v, er_v, lat_v);
    evt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    evt = '0;
    @(posedge clk); #1;
    check("no_irq", {63'd0, irq}, 64'd0);
    xfer(0, 1, NREG - 2, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("evt_ignored", {32'd0, rd_v}, 64'd0);
`endif

    // Reset during the WAIT phase of a read.
    addr  = 7'(2 * 4);
    rd_ce = 1'b1;
    @(posedge clk); #1;
    check("wait_no_ack", {63'd0, ack}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rd_ce = 1'b0;
    check("abort_ack", {63'd0, ack}, 64'd0);
    check("abort_data", {32'd0, rdata}, 64'd0);
    check("abort_irq", {63'd0, irq}, 64'd0);
    saw_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) saw_ack++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) saw_ack++;
    end
    check("abort_never_ack", 64'(saw_ack), 64'd0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    for (int i = 0; i < NREG; i++) begin
      xfer(0, 1, i, '0, 4'h0, '0, rd_v, er_v, lat_v);
      check("post_rst_reg", {32'd0, rd_v}, 64'd0);
    end
    check("post_rst_irq", {63'd0, irq}, 64'd0);

    // First edge after reset release accepts a request.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 0, 0, 32'hCAFEF00D, 4'hF, '0, rd_v, er_v, lat_v);
    check("first_edge_lat", 64'(lat_v), 64'd1);
    xfer(0, 1, 0, '0, 4'h0, '0, rd_v, er_v, lat_v);
    check("first_edge_data", {32'd0, rd_v}, {32'd0, 32'hCAFEF00D});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/user_logic_regbank_irq.md
USER_LOGIC_REGBANK_IRQ -- requirements
Module: user_logic_regbank_irq

Interface
REQ-001 SHALL have parameter C_SLV_DWIDTH, default 32: data bus width in bits; a multiple of 8, from 8 to 64.
REQ-002 SHALL have parameter C_NUM_REG, default 16: register count; a power of 2, from 4 to 64.
REQ-003 SHALL have parameter C_SLV_AWIDTH, default 6: address width; at least 2+log2(C_NUM_REG).
REQ-004 SHALL have parameter C_RD_WAIT, default 1: extra read wait cycles, from 0 to 7.
REQ-005 SHALL have port Bus2IP_Clk  in  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port Bus2IP_Resetn  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port Bus2IP_Addr  in  C_SLV_AWIDTH: byte address; register index = Addr[C_SLV_AWIDTH-1:2].
REQ-008 SHALL have port Bus2IP_Data  in  C_SLV_DWIDTH: write data.
REQ-009 SHALL have port Bus2IP_BE  in  C_SLV_DWIDTH/8: write byte enables.
REQ-010 SHALL have port Bus2IP_WrCE  in  1: write request, held until Ack.
REQ-011 SHALL have port Bus2IP_RdCE  in  1: read request, held until Ack.
REQ-012 SHALL have port IP2Bus_Data  out  C_SLV_DWIDTH: registered read data.
REQ-013 SHALL have port IP2Bus_Ack  out  1: one-cycle transfer-complete pulse.
REQ-014 SHALL have port IP2Bus_Error  out  1: error flag, valid only with Ack.
REQ-015 SHALL have port Evt_In  in  C_SLV_DWIDTH: event inputs, synchronous to Bus2IP_Clk.
REQ-016 SHALL have port Irq  out  1: level interrupt, registered.

Function
REQ-017 SHALL run a transfer FSM with states IDLE, WAIT and ACK.
REQ-018 In IDLE with exactly one of WrCE/RdCE high, the FSM SHALL accept the request.
- Write: goes to ACK.
- Read: goes to WAIT if C_RD_WAIT>0, else to ACK.
REQ-019 WAIT SHALL last exactly C_RD_WAIT cycles, then go to ACK.
REQ-020 ACK SHALL last exactly one cycle with Ack=1, then return to IDLE.
REQ-021 Ack SHALL be high 1 cycle after acceptance for a write, and C_RD_WAIT+1 cycles after acceptance for a read.
REQ-022 A write SHALL update only the bytes whose BE bit is set, in the accept cycle.
REQ-023 Read data SHALL be sampled on entry to ACK; IP2Bus_Data SHALL hold it during ACK and be 0 in all other cycles.
REQ-024 WrCE and RdCE high together in IDLE SHALL give Ack with Error=1, no write, and data 0.
REQ-025 A register index >= C_NUM_REG SHALL give Ack with Error=1, no write, and read data 0.
REQ-026 WrCE/RdCE SHALL be ignored outside IDLE; the master deasserts CE in the cycle after Ack.
REQ-027 Registers 0..C_NUM_REG-3 SHALL be plain read/write; registers C_NUM_REG-2 and C_NUM_REG-1 are governed by REQ-031/032.

Reset
REQ-028 Bus2IP_Resetn low SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE;
- clear all registers and the edge-detect history;
- drive IP2Bus_Data=0, Ack=0, Error=0 and Irq=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no Ack; a write already applied in the accept cycle is also cleared.
REQ-030 After Resetn rises, the first rising edge SHALL be able to accept a request.

Configuration
REQ-031 With USER_LOGIC_IRQ_EN defined:
- register C_NUM_REG-2 SHALL be IRQ_STATUS;
- IRQ_STATUS bit i SHALL set on a rising edge of Evt_In[i] (previous value 0, current value 1);
- writing 1 with BE set SHALL clear a bit;
- a set and a clear of the same bit in the same cycle SHALL leave it set.
REQ-032 With USER_LOGIC_IRQ_EN defined:
- register C_NUM_REG-1 SHALL be IRQ_ENABLE, plain read/write;
- Irq SHALL be registered |(IRQ_STATUS & IRQ_ENABLE), lagging the status/enable change by one cycle.
REQ-033 Without USER_LOGIC_IRQ_EN:
- all C_NUM_REG registers SHALL be plain read/write;
- Evt_In SHALL be ignored;
- Irq SHALL be tied to 0.

Verification
REQ-034 Write reg1=0xA5A5A5A5 (BE=0xF), then write 0x000000FF with BE=0x1 -> read reg1 returns 0xA5A5A5FF; Ack comes 1 cycle after accept for each write, and C_RD_WAIT+1 cycles after accept for the read.
REQ-035 C_NUM_REG=16, C_SLV_AWIDTH=7, address 0x40 (index 16), write then read -> both give Ack with Error=1; read data 0; no register changes.
REQ-036 WrCE and RdCE high together -> Ack with Error=1; a read of the addressed register is unchanged.
REQ-037 With IRQ_EN: write IRQ_ENABLE=0x4; pulse Evt_In[2] -> IRQ_STATUS=0x4 and Irq=1 one cycle later; write IRQ_STATUS=0x4 -> Irq=0; write 0x4 in the same cycle as a new Evt_In[2] rising edge -> bit stays 1.
REQ-038 Assert Resetn low during WAIT of a read with C_RD_WAIT=3 -> Ack never pulses; all registers read 0 after reset; Irq=0.
